// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - instruction/data memory handshake bundle for the sequencer
interface multicycle_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic ir_load;
    logic dmem_req;
    logic dmem_ready;
    logic dmem_we;

    modport master (
        output imem_req,
        output ir_load,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  ir_load,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle fetch/decode/exec/mem/wb control sequencer
// Strobes are a pure decode of the current state and inputs, so they respond in the same cycle.
module multicycle_sequencer #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_sequencer_if.master mem,
    input  logic                 run,
    input  logic                 regwrite_control,
    input  logic                 mem_read_control,
    input  logic                 mem_write_control,
    input  logic                 branch_instruction_control,
    input  logic                 jal_control,
    input  logic                 jalr_control,
    input  logic [3:0]           alu_control,
    input  logic                 branch_taken,
    output logic                 rf_we,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 trap,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   taken_q;
    logic                   taken_use;
    logic                   retire;
    logic [INSTRET_W-1:0]   instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            taken_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXEC) begin
                taken_q <= branch_taken;
            end
            if (retire) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    // The comparator result is live in EXEC; later states use the value captured there.
    assign taken_use = (state_q == S_EXEC) ? branch_taken : taken_q;

    always_comb begin
        state_d      = state_q;
        mem.imem_req = 1'b0;
        mem.ir_load  = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    mem.ir_load = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (alu_control == 4'b1111 && !branch_instruction_control) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (mem_read_control || mem_write_control) begin
                    state_d = S_MEM;
                end else if (regwrite_control) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = mem_write_control;
                if (mem.dmem_ready) begin
                    if (mem_read_control) begin
                        state_d = S_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Retiring overrides whatever the state arm chose for the next state.
        if (retire) begin
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    always_comb begin
        pc_src = 2'b00;
        if (retire) begin
            if (jalr_control) begin
                pc_src = 2'b10;
            end else if (jal_control || (branch_instruction_control && taken_use)) begin
                pc_src = 2'b01;
            end
        end
    end

    assign pc_write = retire;
    assign state    = state_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          regwrite_control, mem_read_control, mem_write_control;
    logic          branch_instruction_control, jal_control, jalr_control;
    logic [3:0]    alu_control;
    logic          branch_taken;
    logic          rf_we, pc_write, trap;
    logic [1:0]    pc_src;
    logic [2:0]    state;
    logic [IW-1:0] instret;

    multicycle_sequencer_if mif();

    multicycle_sequencer #(.INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .mem(mif), .run(run),
        .regwrite_control(regwrite_control), .mem_read_control(mem_read_control),
        .mem_write_control(mem_write_control),
        .branch_instruction_control(branch_instruction_control),
        .jal_control(jal_control), .jalr_control(jalr_control),
        .alu_control(alu_control), .branch_taken(branch_taken),
        .rf_we(rf_we), .pc_write(pc_write), .pc_src(pc_src), .trap(trap),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       ireq, irl, dreq, dwe, rfwe, pcw;
        logic [1:0] src;
        logic       iready, dready;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int retired  = 0;
    bit in_idle  = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input exp_t e);
        check_eq("state",    32'(state),         32'(e.st));
        check_eq("imem_req", 32'(mif.imem_req),  32'(e.ireq));
        check_eq("ir_load",  32'(mif.ir_load),   32'(e.irl));
        check_eq("dmem_req", 32'(mif.dmem_req),  32'(e.dreq));
        check_eq("dmem_we",  32'(mif.dmem_we),   32'(e.dwe));
        check_eq("rf_we",    32'(rf_we),         32'(e.rfwe));
        check_eq("pc_write", 32'(pc_write),      32'(e.pcw));
        check_eq("pc_src",   32'(pc_src),        32'(e.src));
        check_eq("trap",     32'(trap),          32'(e.st == 3'd6));
        check_eq("instret",  32'(instret),       32'(retired % (1 << IW)));
    endtask

    task automatic rand_readies();
        mif.imem_ready = 1'($urandom);
        mif.dmem_ready = 1'($urandom);
        branch_taken   = 1'($urandom);
    endtask

    // Asserted mid-cycle: everything must clear without waiting for a clock edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        retired = 0;
        check_eq("rst_state",    32'(state),        32'd0);
        check_eq("rst_imem_req", 32'(mif.imem_req), 32'd0);
        check_eq("rst_dmem_req", 32'(mif.dmem_req), 32'd0);
        check_eq("rst_rf_we",    32'(rf_we),        32'd0);
        check_eq("rst_pc_write", 32'(pc_write),     32'd0);
        check_eq("rst_pc_src",   32'(pc_src),       32'd0);
        check_eq("rst_trap",     32'(trap),         32'd0);
        check_eq("rst_instret",  32'(instret),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        in_idle = 1'b1;
    endtask

    task automatic idle_go(input int n);
        exp_t e;
        e = '{default: 0};
        for (int i = 0; i <= n; i++) begin
            run = (i == n);
            rand_readies();
            @(negedge clk);
            check_cycle(e);
            @(posedge clk); #1;
        end
        in_idle = 1'b0;
    endtask

    // kind: 0 alu/regwrite, 1 load, 2 store, 3 branch, 4 jal, 5 jalr, 6 no-writeback op, 7 illegal
    // run_mode: 0 random, 1 held high, 2 dropped from EXEC onward
    task automatic do_instr(input int kind, input int id, input int md, input int run_mode,
                            input bit taken, input int abort_at);
        exp_t q[$];
        exp_t e;
        bit   is_mem, is_ld, is_st, rw, br, jal, jalr, wb;
        int   exec_idx;
        logic [1:0] src;

        is_ld = (kind == 1);
        is_st = (kind == 2);
        is_mem = is_ld || is_st;
        rw   = (kind == 0) || is_ld || (kind == 5);
        br   = (kind == 3);
        jal  = (kind == 4);
        jalr = (kind == 5);
        wb   = is_mem ? is_ld : rw;
        src  = jalr ? 2'b10 : ((jal || (br && taken)) ? 2'b01 : 2'b00);

        if (in_idle) idle_go($urandom_range(0, 3));

        regwrite_control           = rw;
        mem_read_control           = is_ld;
        mem_write_control          = is_st;
        branch_instruction_control = br;
        jal_control                = jal;
        jalr_control               = jalr;
        if (kind == 7)      alu_control = 4'hF;
        else if (br)        alu_control = 4'($urandom_range(0, 15));
        else                alu_control = 4'($urandom_range(0, 14));

        for (int k = 0; k <= id; k++) begin
            e = '{default: 0};
            e.st = 3'd1; e.ireq = 1'b1; e.irl = (k == id); e.iready = (k == id);
            e.dready = 1'($urandom);
            q.push_back(e);
        end
        e = '{default: 0}; e.st = 3'd2;
        e.iready = 1'($urandom); e.dready = 1'($urandom);
        q.push_back(e);
        exec_idx = q.size();
        if (kind != 7) begin
            e = '{default: 0}; e.st = 3'd3; e.pcw = !is_mem && !rw;
            e.iready = 1'($urandom); e.dready = 1'($urandom);
            q.push_back(e);
            if (is_mem) begin
                for (int k = 0; k <= md; k++) begin
                    e = '{default: 0};
                    e.st = 3'd4; e.dreq = 1'b1; e.dwe = is_st;
                    e.dready = (k == md); e.pcw = (k == md) && !is_ld;
                    e.iready = 1'($urandom);
                    q.push_back(e);
                end
            end
            if (wb) begin
                e = '{default: 0}; e.st = 3'd5; e.rfwe = 1'b1; e.pcw = 1'b1;
                e.iready = 1'($urandom); e.dready = 1'($urandom);
                q.push_back(e);
            end
        end

        foreach (q[i]) begin
            e = q[i];
            if (e.pcw) e.src = src;
            mif.imem_ready = e.iready;
            mif.dmem_ready = e.dready;
            branch_taken   = (e.st == 3'd3) ? taken : 1'($urandom);
            case (run_mode)
                1:       run = 1'b1;
                2:       run = (i < exec_idx);
                default: run = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            check_cycle(e);
            if (i == abort_at) begin
                pulse_reset();
                return;
            end
            if (e.pcw) retired++;
            @(posedge clk); #1;
        end

        if (kind == 7) begin
            e = '{default: 0}; e.st = 3'd6;
            for (int k = 0; k < 12; k++) begin
                rand_readies();
                run = 1'($urandom);
                @(negedge clk);
                check_cycle(e);
                @(posedge clk); #1;
            end
            @(negedge clk);
            pulse_reset();
        end else begin
            in_idle = !run;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e0;
        e0 = '{default: 0};
        rst = 1'b1; run = 1'b0;
        regwrite_control = 0; mem_read_control = 0; mem_write_control = 0;
        branch_instruction_control = 0; jal_control = 0; jalr_control = 0;
        alu_control = 4'd0; branch_taken = 0;
        mif.imem_ready = 0; mif.dmem_ready = 0;
        repeat (3) @(posedge clk);
        #1 run = 1'b1;
        @(negedge clk);
        check_cycle(e0);
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0; in_idle = 1'b1;

        do_instr(0, 0, 0, 1, 1'b0, -1);
        do_instr(1, 0, 3, 1, 1'b0, -1);
        do_instr(3, 0, 0, 1, 1'b1, -1);
        do_instr(3, 0, 0, 1, 1'b0, -1);
        do_instr(4, 1, 0, 1, 1'b0, -1);
        do_instr(5, 0, 0, 1, 1'b1, -1);
        do_instr(2, 0, 2, 2, 1'b0, -1);

        for (int n = 0; n < 250; n++) begin
            do_instr($urandom_range(0, 6), $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                     $urandom_range(0, 3), 0, 1'($urandom), -1);
        end

        do_instr(1, 0, 5, 1, 1'b0, 5);
        for (int n = 0; n < 17; n++) do_instr(6, 0, 0, 1, 1'b0, -1);
        do_instr(3, 0, 0, 0, 1'b1, -1);
        do_instr(7, 1, 0, 1, 1'b0, -1);
        do_instr(0, 0, 0, 1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
